// File: rtl/ext_bus_bridge_pkg.sv
// Shared definitions for the external bus bridge and its address decoder.
// Holds the FSM state encoding, address-window defaults and the timeout fill value.
package ext_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] EXT_BASE_DEFAULT = 32'hFFFF0000;
    localparam logic [31:0] EXT_MASK_DEFAULT = 32'hFFFF0000;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam int          CNT_W            = 8;

endpackage

// File: rtl/ext_bus_bridge_decode.sv
// Combinational external-window compare; also intended for the instruction-fetch path.
module ext_addr_decode
    import ext_bus_bridge_pkg::*;
#(
    parameter logic [31:0] BASE = EXT_BASE_DEFAULT,
    parameter logic [31:0] MASK = EXT_MASK_DEFAULT
) (
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    output logic        hit
);

    assign hit = (mem_read | mem_write) && ((addr & MASK) == BASE);

endmodule

// File: rtl/ext_bus_bridge.sv
// CPU data-side bridge to the off-chip req/ack memory bus, with pipeline stall and timeout.
// state | meaning
// IDLE  | decode CPU access; internal accesses pass with no added latency
// REQ   | ext_req held, waiting for ext_ack or the timeout terminal count
// DONE  | transfer complete, CPU consumes data this cycle
// ERR   | timeout, ERR_DATA presented and bus_error pulsed
module ext_bus_bridge
    import ext_bus_bridge_pkg::*;
#(
    parameter logic [31:0] EXT_BASE = EXT_BASE_DEFAULT,
    parameter logic [31:0] EXT_MASK = EXT_MASK_DEFAULT,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        stall,
    output logic        chipSelect,
    output logic [31:0] external_memory,
    output logic        bus_error,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic [31:0] ext_rdata,
    input  logic        ext_ack
);

    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             hit;

    ext_addr_decode #(
        .BASE (EXT_BASE),
        .MASK (EXT_MASK)
    ) u_decode (
        .mem_read  (cpu_mem_read),
        .mem_write (cpu_mem_write),
        .addr      (cpu_addr),
        .hit       (hit)
    );

    // Stall must rise in the request cycle itself so the CPU holds the access.
    assign stall = !reset && (((state == ST_IDLE) && hit) || (state == ST_REQ));

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            chipSelect      <= 1'b1;
            external_memory <= '0;
            bus_error       <= 1'b0;
            ext_req         <= 1'b0;
            ext_we          <= 1'b0;
            ext_addr        <= '0;
            ext_wdata       <= '0;
            count           <= '0;
        end else begin
            bus_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (hit) begin
                        ext_addr  <= cpu_addr;
                        ext_wdata <= cpu_wdata;
                        ext_we    <= cpu_mem_write;
                        ext_req   <= 1'b1;
                        count     <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (count != '1) count <= count + 1'b1;
                    // A late ack on the terminal-count cycle still completes the transfer.
                    if (ext_ack) begin
                        ext_req    <= 1'b0;
                        chipSelect <= ext_we;
                        if (!ext_we) external_memory <= ext_rdata;
                        state      <= ST_DONE;
                    end else if (count == TC) begin
                        ext_req         <= 1'b0;
                        chipSelect      <= 1'b0;
                        external_memory <= ERR_DATA;
                        bus_error       <= 1'b1;
                        state           <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    chipSelect <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
